// File: rtl/serial_paralelo_rx_if.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx_if
// Purpose : groups the serial lane input and the parallel byte outputs of the
//           serial-to-parallel receiver into one bundle.
// Signals : data_in   - serial lane bit, MSB of each byte first
//           data_out  - last accepted payload byte
//           valid_out - data_out holds a payload byte
//           active    - lane aligned and trained
// Modports: master - drives the lane, observes the byte outputs (bench / source)
//           slave  - the receiver itself
// -----------------------------------------------------------------------------
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface : serial_paralelo_rx_if

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
// Purpose : bit-serial lane receiver. Hunts for the COMMA symbol at any bit
//           offset, confirms alignment with BC_NEEDED consecutive byte-aligned
//           COMMAs, then deserialises payload bytes, dropping COMMA/IDLE fillers.
// Ports   : clk_32f - bit-rate clock, all state changes on its rising edge
//           reset   - asynchronous, active-high, clears all state
//           bus     - serial_paralelo_rx_if.slave
//                     (data_in in; data_out, valid_out, active out, registered)
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter logic [7:0]  IDLE      = 8'h7C,
    parameter int unsigned BC_NEEDED = 4
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    serial_paralelo_rx_if.slave   bus
);

    localparam int unsigned SR_W  = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned BC_W  = (BC_NEEDED > 1) ? $clog2(BC_NEEDED + 1) : 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t            r_state;
    logic [SR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BC_W-1:0]   r_bc_cnt;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_active;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [BC_W-1:0]   w_bc_cnt_nxt;
    logic [BC_W-1:0]   w_bc_inc;
    logic [7:0]        w_data_nxt;
    logic              w_valid_nxt;
    logic              w_active_nxt;
    logic [7:0]        w_byte;
    logic              w_boundary;
    logic              w_unused;

    // Candidate byte: the seven previous bits plus the bit arriving on this edge.
    assign w_byte     = {r_sr[6:0], bus.data_in};
    assign w_boundary = (r_bit_cnt == CNT_W'(7));
    assign w_bc_inc   = r_bc_cnt + BC_W'(1);

    // The oldest shift-register bit is shifted out before it can ever matter.
    assign w_unused   = r_sr[7];

    // State register and all datapath registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_byte;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bc_cnt  <= w_bc_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_active  <= w_active_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        w_bc_cnt_nxt  = r_bc_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_active_nxt  = r_active;

        case (r_state)
            ST_SEARCH: begin
                // Bit-by-bit hunt; the bit counter is meaningless until aligned.
                w_valid_nxt   = 1'b0;
                w_bit_cnt_nxt = r_bit_cnt;
                if (w_byte == COMMA) begin
                    w_bit_cnt_nxt = '0;
                    w_bc_cnt_nxt  = BC_W'(1);
                    if (BC_NEEDED <= 1) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_TRAIN;
                    end
                end
            end

            ST_TRAIN: begin
                w_valid_nxt = 1'b0;
                if (w_boundary) begin
                    if (w_byte == COMMA) begin
                        w_bc_cnt_nxt = w_bc_inc;
                        if (w_bc_inc == BC_W'(BC_NEEDED)) begin
                            w_state_nxt  = ST_ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        // Misaligned or broken training: hunt again from the next bit.
                        w_state_nxt  = ST_SEARCH;
                        w_bc_cnt_nxt = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                // Sticky: no realignment, fillers only suppress valid.
                if (w_boundary) begin
                    if ((w_byte == COMMA) || (w_byte == IDLE)) begin
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_data_nxt  = w_byte;
                        w_valid_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_SEARCH;
                w_bit_cnt_nxt = '0;
                w_bc_cnt_nxt  = '0;
                w_valid_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.active    = r_active;

endmodule : serial_paralelo_rx

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Purpose : directed self-checking bench for serial_paralelo_rx. Drives the
//           lane through an interface instance; a second instance with
//           BC_NEEDED=1 shares the same lane stream.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_paralelo_rx_if bus_if ();
    serial_paralelo_rx_if bus1_if ();

    serial_paralelo_rx #(.COMMA(8'hBC), .IDLE(8'h7C), .BC_NEEDED(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus_if)
    );

    serial_paralelo_rx #(.COMMA(8'hBC), .IDLE(8'h7C), .BC_NEEDED(1)) dut1 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus1_if)
    );

    always #5 clk_32f = ~clk_32f;

    // Present one bit, let one rising edge take it, return 1 time unit later.
    task automatic send_bit(input logic b);
        bus_if.data_in  = b;
        bus1_if.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    // Reset held across clock edges with a busy lane; released on a falling edge
    // so the next send_bit lands on post-reset edge 1.
    task automatic do_reset();
        reset           = 1'b1;
        bus_if.data_in  = 1'b1;
        bus1_if.data_in = 1'b1;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        reset           = 1'b0;
        bus_if.data_in  = 1'b0;
        bus1_if.data_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus_if.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus_if.data_out); end
        n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid_out); end
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", bus_if.active); end
        n_checks++; if (bus1_if.active !== 1'b0) begin n_fail++; $display("FAIL reset_active_bc1 got=%b exp=0", bus1_if.active); end
    endtask

    // Four aligned commas from edge 1, then two payload bytes.
    task automatic test_train_payload();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL train_active_early k=%0d got=%b exp=0", k, bus_if.active); end
        end
        send_bits(8'hBC, 7);
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL train_active_e31 got=%b exp=0", bus_if.active); end
        send_bit(1'b0);
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL train_active_e32 got=%b exp=1", bus_if.active); end
        n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL train_valid_e32 got=%b exp=0", bus_if.valid_out); end
        send_bits(8'hA5, 7);
        n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL payload_valid_e39 got=%b exp=0", bus_if.valid_out); end
        send_bit(1'b1);
        n_checks++; if (bus_if.data_out !== 8'hA5) begin n_fail++; $display("FAIL payload_data_e40 got=%h exp=a5", bus_if.data_out); end
        n_checks++; if (bus_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL payload_valid_e40 got=%b exp=1", bus_if.valid_out); end
        send_bits(8'h3C, 4);
        n_checks++; if (bus_if.data_out !== 8'hA5) begin n_fail++; $display("FAIL payload_hold_e44 got=%h exp=a5", bus_if.data_out); end
        send_bits(8'hC0, 4);
        n_checks++; if (bus_if.data_out !== 8'h3C) begin n_fail++; $display("FAIL payload_data_e48 got=%h exp=3c", bus_if.data_out); end
        n_checks++; if (bus_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL payload_valid_e48 got=%b exp=1", bus_if.valid_out); end
    endtask

    // Three junk bits shift the comma off a byte grid; search must find it anyway.
    task automatic test_junk_align();
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_bits(8'hBC, 7);
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL junk_active_e34 got=%b exp=0", bus_if.active); end
        send_bit(1'b0);
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL junk_active_e35 got=%b exp=1", bus_if.active); end
        send_byte(8'h5A);
        n_checks++; if (bus_if.data_out !== 8'h5A) begin n_fail++; $display("FAIL junk_data_e43 got=%h exp=5a", bus_if.data_out); end
        n_checks++; if (bus_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL junk_valid_e43 got=%b exp=1", bus_if.valid_out); end
    endtask

    // A non-comma during training restarts the count from scratch.
    task automatic test_broken_train();
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h12);
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL broken_active_e32 got=%b exp=0", bus_if.active); end
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_bits(8'hBC, 7);
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL broken_active_e63 got=%b exp=0", bus_if.active); end
        n_checks++; if (bus_if.valid_out !== 1'b0) begin n_fail++; $display("FAIL broken_valid_e63 got=%b exp=0", bus_if.valid_out); end
        send_bit(1'b0);
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL broken_active_e64 got=%b exp=1", bus_if.active); end
    endtask

    // IDLE and COMMA in ACTIVE clear valid but keep the last payload byte.
    task automatic test_filter();
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        send_byte(8'h11);
        n_checks++; if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== 8'h11) begin n_fail++; $display("FAIL filter_payload got=%b/%h exp=1/11", bus_if.valid_out, bus_if.data_out); end
        send_byte(8'h7C);
        n_checks++; if (bus_if.valid_out !== 1'b0 || bus_if.data_out !== 8'h11) begin n_fail++; $display("FAIL filter_idle got=%b/%h exp=0/11", bus_if.valid_out, bus_if.data_out); end
        send_byte(8'hBC);
        n_checks++; if (bus_if.valid_out !== 1'b0 || bus_if.data_out !== 8'h11) begin n_fail++; $display("FAIL filter_comma got=%b/%h exp=0/11", bus_if.valid_out, bus_if.data_out); end
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL filter_active got=%b exp=1", bus_if.active); end
    endtask

    // Continues from test_filter: consecutive payloads, near-filter values, stickiness.
    task automatic test_back_to_back();
        logic [7:0] vec [4];
        vec[0] = 8'h7D; vec[1] = 8'hBD; vec[2] = 8'h00; vec[3] = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            send_byte(vec[k]);
            n_checks++; if (bus_if.valid_out !== 1'b1 || bus_if.data_out !== vec[k]) begin n_fail++; $display("FAIL b2b k=%0d got=%b/%h exp=1/%h", k, bus_if.valid_out, bus_if.data_out, vec[k]); end
        end
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(8'h00);
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL sticky_active got=%b exp=1", bus_if.active); end
    endtask

    // Reset mid-byte clears outputs without a clock edge; retraining needs 4 commas.
    task automatic test_async_reset();
        send_byte(8'hE7);
        n_checks++; if (bus_if.data_out === 8'h00) begin n_fail++; $display("FAIL areset_pre got=%h exp=nonzero", bus_if.data_out); end
        send_bits(8'hA0, 3);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus_if.data_out !== 8'h00 || bus_if.valid_out !== 1'b0 || bus_if.active !== 1'b0) begin n_fail++; $display("FAIL areset_outputs got=%h/%b/%b exp=00/0/0", bus_if.data_out, bus_if.valid_out, bus_if.active); end
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL areset_retrain_early got=%b exp=0", bus_if.active); end
        send_byte(8'hBC);
        n_checks++; if (bus_if.active !== 1'b1) begin n_fail++; $display("FAIL areset_retrain got=%b exp=1", bus_if.active); end
    endtask

    // BC_NEEDED=1 goes active on the first comma match.
    task automatic test_bc1();
        do_reset();
        send_bits(8'hBC, 7);
        n_checks++; if (bus1_if.active !== 1'b0) begin n_fail++; $display("FAIL bc1_active_e7 got=%b exp=0", bus1_if.active); end
        send_bit(1'b0);
        n_checks++; if (bus1_if.active !== 1'b1) begin n_fail++; $display("FAIL bc1_active_e8 got=%b exp=1", bus1_if.active); end
        send_byte(8'h5A);
        n_checks++; if (bus1_if.data_out !== 8'h5A || bus1_if.valid_out !== 1'b1) begin n_fail++; $display("FAIL bc1_data got=%h/%b exp=5a/1", bus1_if.data_out, bus1_if.valid_out); end
        n_checks++; if (bus_if.active !== 1'b0) begin n_fail++; $display("FAIL bc4_still_training got=%b exp=0", bus_if.active); end
    endtask

    initial begin
        bus_if.data_in  = 1'b0;
        bus1_if.data_in = 1'b0;
        test_reset();
        test_train_payload();
        test_junk_align();
        test_broken_train();
        test_filter();
        test_back_to_back();
        test_async_reset();
        test_bc1();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_paralelo_rx
